endpoint_csr_ctrl: RTL
======================

Name: endpoint_csr_ctrl

Overview:
Next-generation endpoint control/status register block. It sits between the peripheral bus and the endpoint TX/RX datapath, and replaces the single-cycle send trigger with a queued send-request FIFO. It holds per-message packet start addresses and a writable node ID, counts RX and TX-done events, and raises a maskable, registered interrupt.

Parameters:
- NUM_MSGS, 4: number of message slots. Power of 2, >=2.
- CACHE_NUM_WORDS, 128: TX cache depth in words. Sets ADDR_WIDTH = $clog2(CACHE_NUM_WORDS)+2 (localparam).
- SEND_FIFO_DEPTH, 4: send-request queue entries. Power of 2, >=2.
- CNT_WIDTH, 16: width of the event counters.

Ports:
- clk, in, 1: clock.
- n_rst, in, 1: asynchronous active-low reset.
- bus_addr, in, 32: byte address. Word aligned; bits [1:0] are ignored.
- bus_wen, in, 1: write enable.
- bus_ren, in, 1: read enable.
- bus_wdata, in, 32: write data.
- bus_rdata, out, 32: read data. Combinational, same cycle.
- bus_error, out, 1: access error. Combinational, same cycle.
- bus_request_stall, out, 1: tied to 0. All accesses complete in one cycle.
- node_id, out, 8: node ID register.
- pkt_start_addr, out, NUM_MSGS*ADDR_WIDTH: packed start addresses, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- send_valid, out, 1: queue head is valid.
- send_msg_id, out, $clog2(NUM_MSGS): queue head message ID.
- send_ready, in, 1: TX FSM accepts the head entry.
- tx_done, in, 1: single-cycle pulse, TX FSM finished a message.
- rx_pkt_done, in, 1: single-cycle pulse, RX cache completed a packet.
- irq, out, 1: registered interrupt.

Behaviour:
- Reset (async, n_rst=0): all registers, counters, pending bits and enables go to 0. FIFO empties. send_valid=0, send_msg_id=0, irq=0, node_id=0, pkt_start_addr=0. Reset mid-operation discards queued sends.
- Bus priority: if bus_wen and bus_ren are both high, the access is a write. Writes update registers on the clock edge. Reads are combinational from current state.
- Register map:
  - 0x0000+4*i, i<NUM_MSGS: PKT_START[i], RW. Write stores wdata[ADDR_WIDTH-1:0] & ~3. Read zero-extends.
  - 0x1000 NODE_ID, RW, bits [7:0].
  - 0x1004 TX_SEND, WO:
    - wdata < NUM_MSGS: push wdata[$clog2(NUM_MSGS)-1:0].
    - wdata >= NUM_MSGS: bus_error=1, no push.
    - Push while full with no pop in the same cycle: bus_error=1, no push, OVF sticky set.
    - Full with a simultaneous pop: push accepted, count unchanged.
    - Read of TX_SEND: rdata=0, no error.
  - 0x1008 STATUS:
    - Read: [7:0] FIFO count, [8] full, [9] empty, [10] OVF, [11] irq.
    - Write: 1 to bit 10 clears OVF. If an overflow occurs in the same cycle, set wins.
  - 0x100C RX_COUNT, R. Counts rx_pkt_done pulses, saturates at 2^CNT_WIDTH-1. Any write clears it; an event in the same cycle as the clear yields 1.
  - 0x1010 TXDONE_COUNT: same rules as RX_COUNT, counting tx_done.
  - 0x1014 IRQ_EN, RW, bits [2:0]: [0] rx, [1] tx_done, [2] OVF.
  - 0x1018 IRQ_PEND, R/W1C, bits [2:0]:
    - Set on rx_pkt_done, on tx_done, and on an overflow event respectively.
    - Set wins over a same-cycle clear.
  - Unmapped address: bus_error=1, rdata=32'hBAD1BAD1, no state change.
- Send FIFO:
  - send_valid = !empty; send_msg_id = head entry.
  - Pop on send_valid && send_ready.
  - No write-through: a push into an empty FIFO makes send_valid visible the next cycle.
  - Pointers wrap modulo SEND_FIFO_DEPTH. Count width is $clog2(SEND_FIFO_DEPTH+1).
  - send_ready while empty has no effect.
- irq <= |(IRQ_PEND & IRQ_EN), one cycle after pending or enable changes.

Decomposition:
- chiplet_types_pkg gains:
  - the register offset localparams (CSR_PKT_START_BASE, CSR_NODE_ID, CSR_TX_SEND, CSR_STATUS, CSR_RX_COUNT, CSR_TXDONE_COUNT, CSR_IRQ_EN, CSR_IRQ_PEND);
  - STATUS and IRQ bit-index constants;
  - the BAD_ADDR_DATA constant 32'hBAD1BAD1.
- Sub-module send_fifo: synchronous FIFO, params WIDTH and DEPTH. Ports push, pop, wdata, rdata, full, empty, count.

Test Plan:
- Write 0x0007 to 0x0004 -> PKT_START[1]=0x4, read at 0x0004 returns 0x4. Write 0x1000=0x2A -> node_id=0x2A.
- Write 0x1004 with 2, 0, 3 while send_ready=0 -> count=3, send_valid=1, send_msg_id=2. Raise send_ready -> IDs 2,0,3 pop on successive cycles, then empty=1.
- Fill with 4 pushes, then push 1 with send_ready=0 -> bus_error=1, STATUS[10]=1, count stays 4. Same push with send_ready=1 -> accepted, count=4. Write 0x1008=0x400 -> OVF cleared.
- Write 0x1004=4 or read 0x2000 -> bus_error=1; the 0x2000 read returns 0xBAD1BAD1; FIFO unchanged.
- IRQ_EN=0x1, pulse rx_pkt_done -> IRQ_PEND[0]=1 and irq=1 one cycle later, RX_COUNT=1. W1C 0x1018=1 in the same cycle as a new pulse -> pending stays 1, RX_COUNT=2.
- Assert n_rst=0 with 3 queued sends and irq=1 -> send_valid, irq, counters and FIFO count all 0 immediately.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg
// Shared constants for the endpoint CSR block: register byte offsets,
// STATUS / IRQ bit positions and the read value returned for unmapped
// addresses. No ports; imported by endpoint_csr_ctrl.
package chiplet_types_pkg;

  // Register byte offsets (word aligned)
  localparam logic [31:0] CSR_PKT_START_BASE = 32'h0000_0000;
  localparam logic [31:0] CSR_NODE_ID        = 32'h0000_1000;
  localparam logic [31:0] CSR_TX_SEND        = 32'h0000_1004;
  localparam logic [31:0] CSR_STATUS         = 32'h0000_1008;
  localparam logic [31:0] CSR_RX_COUNT       = 32'h0000_100C;
  localparam logic [31:0] CSR_TXDONE_COUNT   = 32'h0000_1010;
  localparam logic [31:0] CSR_IRQ_EN         = 32'h0000_1014;
  localparam logic [31:0] CSR_IRQ_PEND       = 32'h0000_1018;

  // STATUS fields: [7:0] holds the send FIFO count
  localparam int STATUS_FULL_BIT  = 8;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_OVF_BIT   = 10;
  localparam int STATUS_IRQ_BIT   = 11;

  // IRQ_EN / IRQ_PEND bit positions
  localparam int IRQ_RX_BIT     = 0;
  localparam int IRQ_TXDONE_BIT = 1;
  localparam int IRQ_OVF_BIT    = 2;
  localparam int IRQ_NUM        = 3;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/send_fifo.sv
// send_fifo
// Small synchronous FIFO holding queued send-request message IDs.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   push, wdata     : enqueue wdata (ignored when full unless popping too)
//   pop             : dequeue head (ignored when empty)
//   rdata           : current head entry (registered storage, no bypass)
//   full, empty     : occupancy flags
//   count           : number of stored entries
module send_fifo #(
  parameter int  WIDTH = 2,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too so the head reads 0 straight out of reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/endpoint_csr_ctrl.sv
// endpoint_csr_ctrl
// Endpoint control/status registers between the peripheral bus and the
// TX/RX datapath: packet start addresses, node ID, queued send requests,
// RX / TX-done event counters and a maskable registered interrupt.
// Ports:
//   clk, n_rst                 : clock, asynchronous active-low reset
//   bus_addr/wen/ren/wdata     : single-cycle register access (write wins)
//   bus_rdata, bus_error       : combinational read data / access error
//   bus_request_stall          : always 0
//   node_id, pkt_start_addr    : configuration outputs
//   send_valid, send_msg_id    : head of send-request queue
//   send_ready                 : TX FSM takes the head entry
//   tx_done, rx_pkt_done       : event pulses
//   irq                        : registered interrupt
module endpoint_csr_ctrl
  import chiplet_types_pkg::*;
#(
  parameter int  NUM_MSGS        = 4,
  parameter int  CACHE_NUM_WORDS = 128,
  parameter int  SEND_FIFO_DEPTH = 4,
  parameter int  CNT_WIDTH       = 16,
  localparam int ADDR_WIDTH      = $clog2(CACHE_NUM_WORDS) + 2,
  localparam int MSG_W           = $clog2(NUM_MSGS)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [31:0]                    bus_addr,
  input  logic                           bus_wen,
  input  logic                           bus_ren,
  input  logic [31:0]                    bus_wdata,
  output logic [31:0]                    bus_rdata,
  output logic                           bus_error,
  output logic                           bus_request_stall,
  output logic [7:0]                     node_id,
  output logic [NUM_MSGS*ADDR_WIDTH-1:0] pkt_start_addr,
  output logic                           send_valid,
  output logic [MSG_W-1:0]               send_msg_id,
  input  logic                           send_ready,
  input  logic                           tx_done,
  input  logic                           rx_pkt_done,
  output logic                           irq
);

  localparam int FCNT_W = $clog2(SEND_FIFO_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] pkt_q [NUM_MSGS];
  logic [ADDR_WIDTH-1:0] pkt_d [NUM_MSGS];
  logic [7:0]            node_id_q, node_id_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [IRQ_NUM-1:0]    irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  logic                  irq_q, irq_d;

  logic [31:0]       word_addr, pkt_off, status_word;
  logic [MSG_W-1:0]  pkt_idx;
  logic              mapped;
  logic              wr_pkt, wr_node, wr_send, wr_status;
  logic              wr_rx, wr_tx, wr_en, wr_pend;
  logic [IRQ_NUM-1:0] irq_events, irq_w1c;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              send_id_ok, ovf_event;
  logic [FCNT_W-1:0] fifo_count;
  logic [MSG_W-1:0]  fifo_head;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr[1:0];

  assign word_addr = {bus_addr[31:2], 2'b00};
  assign pkt_off   = word_addr - CSR_PKT_START_BASE;
  assign pkt_idx   = pkt_off[2 +: MSG_W];

  always_comb begin
    status_word                   = '0;
    status_word[7:0]              = 8'(fifo_count);
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_OVF_BIT]   = ovf_q;
    status_word[STATUS_IRQ_BIT]   = irq_q;
  end

  // Address decode, write strobes and combinational read mux
  always_comb begin
    mapped    = 1'b1;
    wr_pkt    = 1'b0;
    wr_node   = 1'b0;
    wr_send   = 1'b0;
    wr_status = 1'b0;
    wr_rx     = 1'b0;
    wr_tx     = 1'b0;
    wr_en     = 1'b0;
    wr_pend   = 1'b0;
    bus_rdata = '0;
    if (pkt_off < 32'(NUM_MSGS * 4)) begin
      wr_pkt    = bus_wen;
      bus_rdata = 32'(pkt_q[pkt_idx]);
    end else begin
      case (word_addr)
        CSR_NODE_ID: begin
          wr_node   = bus_wen;
          bus_rdata = {24'd0, node_id_q};
        end
        CSR_TX_SEND:      wr_send = bus_wen;
        CSR_STATUS: begin
          wr_status = bus_wen;
          bus_rdata = status_word;
        end
        CSR_RX_COUNT: begin
          wr_rx     = bus_wen;
          bus_rdata = 32'(rx_cnt_q);
        end
        CSR_TXDONE_COUNT: begin
          wr_tx     = bus_wen;
          bus_rdata = 32'(tx_cnt_q);
        end
        CSR_IRQ_EN: begin
          wr_en     = bus_wen;
          bus_rdata = 32'(irq_en_q);
        end
        CSR_IRQ_PEND: begin
          wr_pend   = bus_wen;
          bus_rdata = 32'(irq_pend_q);
        end
        default: begin
          mapped    = 1'b0;
          bus_rdata = BAD_ADDR_DATA;
        end
      endcase
    end
  end

  // Send queue control: an in-range ID pushes unless the queue is full and
  // nothing leaves this cycle, in which case it is dropped as an overflow.
  assign send_id_ok = (bus_wdata < 32'(NUM_MSGS));
  assign fifo_pop   = !fifo_empty && send_ready;
  assign fifo_push  = wr_send && send_id_ok && (!fifo_full || fifo_pop);
  assign ovf_event  = wr_send && send_id_ok && fifo_full && !fifo_pop;

  assign bus_error = ((bus_wen || bus_ren) && !mapped)
                   || (wr_send && !send_id_ok)
                   || ovf_event;
  assign bus_request_stall = 1'b0;

  send_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (SEND_FIFO_DEPTH)
  ) u_send_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus_wdata[MSG_W-1:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Saturating event counter; a clear coinciding with an event leaves 1
  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 ev,
    input logic                 clr
  );
    if (clr) begin
      return CNT_WIDTH'(ev);
    end else if (ev && (cur != CNT_MAX)) begin
      return cur + 1'b1;
    end
    return cur;
  endfunction

  always_comb begin
    irq_events                 = '0;
    irq_events[IRQ_RX_BIT]     = rx_pkt_done;
    irq_events[IRQ_TXDONE_BIT] = tx_done;
    irq_events[IRQ_OVF_BIT]    = ovf_event;
    irq_w1c = wr_pend ? bus_wdata[IRQ_NUM-1:0] : '0;

    pkt_d = pkt_q;
    if (wr_pkt) begin
      pkt_d[pkt_idx] = {bus_wdata[ADDR_WIDTH-1:2], 2'b00};
    end
    node_id_d  = wr_node ? bus_wdata[7:0] : node_id_q;
    // A new overflow beats a same-cycle clear
    ovf_d      = ovf_event || (ovf_q && !(wr_status && bus_wdata[STATUS_OVF_BIT]));
    rx_cnt_d   = cnt_next(rx_cnt_q, rx_pkt_done, wr_rx);
    tx_cnt_d   = cnt_next(tx_cnt_q, tx_done, wr_tx);
    irq_en_d   = wr_en ? bus_wdata[IRQ_NUM-1:0] : irq_en_q;
    irq_pend_d = (irq_pend_q & ~irq_w1c) | irq_events;
    irq_d      = |(irq_pend_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_MSGS; i++) begin
        pkt_q[i] <= '0;
      end
      node_id_q  <= '0;
      ovf_q      <= 1'b0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      irq_en_q   <= '0;
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      node_id_q  <= node_id_d;
      ovf_q      <= ovf_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  for (genvar gi = 0; gi < NUM_MSGS; gi++) begin : g_pkt_out
    assign pkt_start_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = pkt_q[gi];
  end

  assign node_id     = node_id_q;
  assign send_valid  = !fifo_empty;
  assign send_msg_id = fifo_head;
  assign irq         = irq_q;

endmodule
